// File: rtl/read_burst_scheduler.sv
// AXI read burst sequencer for one video read channel.
// Issues normal or tail bursts from a frame base, gated on FIFO space.
module read_burst_scheduler #(
  parameter int NOR_BURST_LEN = 200,
  parameter int AXI_DSIZE     = 256,
  parameter int LSIZE         = 9,
  parameter int ASIZE         = 32,
  parameter int SETTLE        = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fsync,
  input  logic [ASIZE-1:0] baseaddr,
  input  logic [LSIZE-1:0] fifo_space,
  input  logic             tail_status,
  input  logic [LSIZE-1:0] tail_len,
  input  logic             frame_tail_leave,
  output logic [ASIZE-1:0] axi_araddr,
  output logic [7:0]       axi_arlen,
  output logic             axi_arvalid,
  input  logic             axi_arready,
  input  logic             axi_rvalid,
  input  logic             axi_rlast,
  output logic             axi_rready,
  output logic             burst_done,
  output logic             tail_done,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [ASIZE-1:0] STEP = ASIZE'(AXI_DSIZE / 8);
  localparam logic [LSIZE-1:0] NOR_LEN = LSIZE'(NOR_BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_FEND
  } state_t;

  state_t           state;
  logic [ASIZE-1:0] addr;
  logic [ASIZE-1:0] pend_addr;
  logic             fsync_pend;
  logic [CW-1:0]    cnt;
  logic             is_tail;
  logic             last;
  logic [LSIZE-1:0] blen;
  logic [ASIZE-1:0] blen_ext;
  logic [ASIZE-1:0] next_addr;
  logic             restart;

  assign blen_ext  = ASIZE'(blen);
  assign next_addr = addr + blen_ext * STEP;
  assign restart   = fsync_pend || fsync;
  assign busy      = !(state inside {S_IDLE, S_FEND});

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      pend_addr   <= '0;
      fsync_pend  <= 1'b0;
      cnt         <= '0;
      is_tail     <= 1'b0;
      last        <= 1'b0;
      blen        <= '0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      burst_done  <= 1'b0;
      tail_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      tail_done  <= 1'b0;
      // a frame restart mid-burst must let the AXI handshakes finish
      if (fsync && (state == S_ADDR || state == S_DATA)) begin
        fsync_pend <= 1'b1;
        pend_addr  <= baseaddr;
      end
      case (state)
        S_IDLE, S_FEND: begin
          if (fsync) begin
            addr       <= baseaddr;
            frame_done <= 1'b0;
            cnt        <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (fsync) begin
            addr <= baseaddr;
            cnt  <= '0;
          end else if (cnt == SET_LAST) begin
            is_tail <= tail_status;
            blen    <= tail_status ? tail_len : NOR_LEN;
            last    <= frame_tail_leave;
            state   <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (fsync) begin
            addr  <= baseaddr;
            cnt   <= '0;
            state <= S_SETTLE;
          end else if (enable && fifo_space >= blen) begin
            axi_arvalid <= 1'b1;
            axi_araddr  <= addr;
            axi_arlen   <= 8'(blen - LSIZE'(1));
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          // rlast alone ends the burst; the beat count is not trusted
          if (axi_rvalid && axi_rlast) begin
            axi_rready <= 1'b0;
            burst_done <= !is_tail && !restart;
            tail_done  <= is_tail && !restart;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          addr <= next_addr;
          cnt  <= '0;
          if (restart) begin
            addr       <= fsync ? baseaddr : pend_addr;
            fsync_pend <= 1'b0;
            frame_done <= 1'b0;
            state      <= S_SETTLE;
          end else if (is_tail && last) begin
            frame_done <= 1'b1;
            state      <= S_FEND;
          end else if (!enable) begin
            state <= S_IDLE;
          end else begin
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
